// File: rtl/pattern_loader.sv
// Serial pattern-buffer loader: streams one BUF_BYTES frame MSB first over
// sclk/sin/ssel and collects the sout readback into whole bytes.
module pattern_loader #(
  parameter int BUF_BYTES = 16,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] buf_addr,
  input  logic       abort,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_byte,
  output logic       rb_valid,
  output logic       sclk,
  output logic       sin,
  output logic       ssel,
  output logic [2:0] saddr,
  input  logic       sout
);

  localparam int BYTE_W = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, SHIFT_LO, SHIFT_HI, HOLD
  } state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_div;
  logic [2:0]        r_bit;
  logic [BYTE_W-1:0] r_byte;
  logic [7:0]        r_shreg;
  logic [7:0]        r_rbsh;
  logic [7:0]        r_rb_byte;
  logic              r_rb_valid;
  logic              r_sin;
  logic              r_done;
  logic [2:0]        r_saddr;

  logic w_div_last;
  logic w_last_byte;
  logic w_accept;
  logic w_sample;
  logic w_timed;

  assign w_div_last  = (r_div == 4'(CLK_DIV - 1));
  assign w_last_byte = (r_byte == BYTE_W'(BUF_BYTES - 1));
  assign w_accept    = (r_state == LOAD) && byte_valid && !abort;
  assign w_sample    = (r_state == SHIFT_HI) && w_div_last && !abort;
  assign w_timed     = (r_state == SETUP) || (r_state == SHIFT_LO) ||
                       (r_state == SHIFT_HI) || (r_state == HOLD);

  assign done     = r_done;
  assign rb_byte  = r_rb_byte;
  assign rb_valid = r_rb_valid;
  assign sin      = r_sin;
  assign saddr    = r_saddr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Serial-port outputs are decoded straight from state so that the async
  // reset clears them in the same cycle it is asserted.
  always_comb begin
    w_next     = r_state;
    byte_ready = 1'b0;
    busy       = 1'b1;
    ssel       = 1'b1;
    sclk       = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        ssel = 1'b0;
        if (start) w_next = SETUP;
      end
      SETUP:    if (w_div_last) w_next = LOAD;
      LOAD: begin
        byte_ready = 1'b1;
        if (byte_valid) w_next = SHIFT_LO;
      end
      SHIFT_LO: if (w_div_last) w_next = SHIFT_HI;
      SHIFT_HI: begin
        sclk = 1'b1;
        if (w_div_last) begin
          if (r_bit != 3'd0)    w_next = SHIFT_LO;
          else if (w_last_byte) w_next = HOLD;
          else                  w_next = LOAD;
        end
      end
      HOLD:     if (w_div_last) w_next = IDLE;
      default: begin
        w_next = IDLE;
        busy   = 1'b0;
        ssel   = 1'b0;
      end
    endcase
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div      <= '0;
      r_bit      <= '0;
      r_byte     <= '0;
      r_sin      <= 1'b0;
      r_saddr    <= '0;
      r_done     <= 1'b0;
      r_rb_valid <= 1'b0;
      r_rb_byte  <= '0;
    end else begin
      r_done     <= (r_state == HOLD) && w_div_last && !abort;
      r_rb_valid <= 1'b0;

      if (w_next != r_state) r_div <= '0;
      else if (w_timed)      r_div <= r_div + 4'd1;

      if ((r_state == IDLE) && start) begin
        r_saddr <= buf_addr;
        r_byte  <= '0;
        r_bit   <= '0;
      end

      if (w_accept) begin
        r_bit <= 3'd7;
        r_sin <= byte_in[7];
      end

      // Bit 0 completes a byte: publish readback, advance without wrapping.
      if (w_sample) begin
        if (r_bit != 3'd0) begin
          r_bit <= r_bit - 3'd1;
          r_sin <= r_shreg[7];
        end else begin
          r_rb_byte  <= {r_rbsh[6:0], sout};
          r_rb_valid <= 1'b1;
          if (!w_last_byte) r_byte <= r_byte + BYTE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_shreg <= {byte_in[6:0], 1'b0};
    else if (w_sample && (r_bit != 3'd0))
      r_shreg <= {r_shreg[6:0], 1'b0};

    if (r_state == IDLE)
      r_rbsh <= '0;
    else if (w_sample)
      r_rbsh <= {r_rbsh[6:0], sout};
  end

endmodule
